// File: rtl/fp_mult_round_pack.sv
// FP multiplier round-and-pack stage.
// Two-stage pipeline: S1 registers the operands and unbiases the exponent, S2 applies the
// rounding increment, classifies the result (zero / overflow / underflow / normal) and packs
// it as {sign, exp[2:0], man[3:0]}. Valid/ready handshake on both sides.
// Optional feature: define FP_ROUND_SATURATE_EN to saturate overflow to the maximum finite
// value instead of producing infinity.
module fp_mult_round_pack #(
  parameter int unsigned BIAS    = 3,
  parameter int unsigned EXP_MAX = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sign,
  input  logic [3:0] in_norm_e,
  input  logic [3:0] in_norm_m,
  input  logic       in_round_up,
  input  logic       in_zero,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_result,
  output logic       out_ovf,
  output logic       out_unf,
  input  logic       flags_clr,
  output logic       sticky_ovf,
  output logic       sticky_unf
);

  localparam logic signed [5:0] BiasS   = 6'(BIAS);
  localparam logic signed [5:0] ExpMaxS = 6'(EXP_MAX);

`ifdef FP_ROUND_SATURATE_EN
  localparam logic [6:0] OvfMag = {3'b110, 4'b1111};
`else
  localparam logic [6:0] OvfMag = {3'b111, 4'b0000};
`endif

  // S1 state
  logic              s1_valid_q;
  logic              s1_sign_q;
  logic signed [5:0] s1_e1_q;
  logic        [3:0] s1_m_q;
  logic              s1_round_q;
  logic              s1_zero_q;
  logic signed [5:0] s1_e1_d;

  // S2 state
  logic              s2_valid_q;
  logic        [7:0] s2_result_q;
  logic              s2_ovf_q;
  logic              s2_unf_q;
  logic        [7:0] s2_result_d;
  logic              s2_ovf_d;
  logic              s2_unf_d;

  logic              sticky_ovf_q, sticky_ovf_d;
  logic              sticky_unf_q, sticky_unf_d;

  logic              s2_can_load;
  logic              in_xfer;
  logic              out_xfer;
  logic        [4:0] m5;
  logic        [3:0] man;
  logic signed [5:0] e2;

  assign s2_can_load = !s2_valid_q || out_ready;
  assign in_ready    = !s1_valid_q || s2_can_load;
  assign in_xfer     = in_valid && in_ready;
  assign out_xfer    = s2_valid_q && out_ready;

  assign s1_e1_d = $signed({2'b00, in_norm_e}) - BiasS;

  // S1 valid bit and operand capture
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
    end
    if (in_xfer) begin
      s1_sign_q  <= in_sign;
      s1_e1_q    <= s1_e1_d;
      s1_m_q     <= in_norm_m;
      s1_round_q <= in_round_up;
      s1_zero_q  <= in_zero;
    end
  end

  // Round, renormalise and classify the S1 beat
  always_comb begin
    m5          = {1'b0, s1_m_q} + {4'b0000, s1_round_q};
    man         = m5[3:0];
    e2          = s1_e1_q;
    s2_result_d = {s1_sign_q, 7'd0};
    s2_ovf_d    = 1'b0;
    s2_unf_d    = 1'b0;
    if (m5[4]) begin
      // Mantissa carried out: 1.1111 + ulp becomes 10.0000
      man = 4'b0000;
      e2  = s1_e1_q + 6'sd1;
    end
    if (s1_zero_q) begin
      s2_result_d = {s1_sign_q, 7'd0};
    end else if (e2 >= ExpMaxS) begin
      s2_ovf_d    = 1'b1;
      s2_result_d = {s1_sign_q, OvfMag};
    end else if (e2 <= 6'sd0) begin
      s2_unf_d    = 1'b1;
      s2_result_d = {s1_sign_q, 7'd0};
    end else begin
      s2_result_d = {s1_sign_q, e2[2:0], man};
    end
  end

  // S2 output register; holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= 8'd0;
      s2_ovf_q    <= 1'b0;
      s2_unf_q    <= 1'b0;
    end else if (s2_can_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_result_q <= s2_result_d;
        s2_ovf_q    <= s2_ovf_d;
        s2_unf_q    <= s2_unf_d;
      end
    end
  end

  // Sticky flag next state; a flagged transfer wins over a simultaneous clear
  always_comb begin
    sticky_ovf_d = sticky_ovf_q;
    sticky_unf_d = sticky_unf_q;
    if (flags_clr) begin
      sticky_ovf_d = 1'b0;
      sticky_unf_d = 1'b0;
    end
    if (out_xfer && s2_ovf_q) begin
      sticky_ovf_d = 1'b1;
    end
    if (out_xfer && s2_unf_q) begin
      sticky_unf_d = 1'b1;
    end
  end

  // Sticky flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_ovf    = s2_ovf_q;
  assign out_unf    = s2_unf_q;
  assign sticky_ovf = sticky_ovf_q;
  assign sticky_unf = sticky_unf_q;

endmodule

// File: tb/tb_fp_mult_round_pack.sv
// Self-checking bench for fp_mult_round_pack: directed vector table, hand-written handshake
// and reset sequences, and a randomized phase scored against a queue-based reference model.
module tb_fp_mult_round_pack;

  localparam int Bias   = 3;
  localparam int ExpMax = 7;

`ifdef FP_ROUND_SATURATE_EN
  localparam logic [6:0] OvfMag = 7'h6F;
`else
  localparam logic [6:0] OvfMag = 7'h70;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_sign;
  logic [3:0] in_norm_e;
  logic [3:0] in_norm_m;
  logic       in_round_up;
  logic       in_zero;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_ovf;
  logic       out_unf;
  logic       flags_clr;
  logic       sticky_ovf;
  logic       sticky_unf;

  always #5 clk = ~clk;

  fp_mult_round_pack dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_norm_e  (in_norm_e),
    .in_norm_m  (in_norm_m),
    .in_round_up(in_round_up),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf),
    .flags_clr  (flags_clr),
    .sticky_ovf (sticky_ovf),
    .sticky_unf (sticky_unf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat packing: {sign, e[3:0], m[3:0], round_up, zero}
  function automatic logic [9:0] model(input logic [10:0] b);
    int         ev;
    int         mv;
    logic       s;
    logic [7:0] res;
    logic       ovf;
    logic       unf;
    s   = b[10];
    ev  = int'(b[9:6]) - Bias;
    mv  = int'(b[5:2]) + int'(b[1]);
    ovf = 1'b0;
    unf = 1'b0;
    if (mv >= 16) begin
      mv = mv - 16;
      ev = ev + 1;
    end
    if (b[0]) begin
      res = {s, 7'd0};
    end else if (ev >= ExpMax) begin
      ovf = 1'b1;
      res = {s, OvfMag};
    end else if (ev <= 0) begin
      unf = 1'b1;
      res = {s, 7'd0};
    end else begin
      res = {s, 3'(ev), 4'(mv)};
    end
    return {ovf, unf, res};
  endfunction

  function automatic logic [10:0] rnd_beat();
    logic [10:0] b;
    b    = 11'($urandom);
    b[0] = ($urandom_range(0, 7) == 0);
    return b;
  endfunction

  task automatic drive(input logic [10:0] b);
    in_sign     = b[10];
    in_norm_e   = b[9:6];
    in_norm_m   = b[5:2];
    in_round_up = b[1];
    in_zero     = b[0];
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one beat (pipeline assumed able to accept) and wait for out_valid
  task automatic send_wait(input logic [10:0] b, output int lat);
    drive(b);
    in_valid = 1'b1;
    #1;
    chk("send_in_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 8) begin
      cyc();
      lat++;
      #1;
    end
  endtask

  // Scoreboard: expected results queue plus sticky flag model
  logic [9:0] sbq[$];
  bit         mon_en = 1'b0;
  logic       m_sovf = 1'b0;
  logic       m_sunf = 1'b0;
  logic [9:0] mon_e;
  logic       nx_ovf;
  logic       nx_unf;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        sbq.delete();
        m_sovf = 1'b0;
        m_sunf = 1'b0;
      end else begin
        chk("sticky_ovf", sticky_ovf, m_sovf);
        chk("sticky_unf", sticky_unf, m_sunf);
        nx_ovf = flags_clr ? 1'b0 : m_sovf;
        nx_unf = flags_clr ? 1'b0 : m_sunf;
        if (out_valid) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stale_out: got out_valid=1 result 0x%0h want no output", out_result);
          end else begin
            mon_e = sbq[0];
            chk("sb_result", out_result, mon_e[7:0]);
            chk("sb_ovf", out_ovf, mon_e[9]);
            chk("sb_unf", out_unf, mon_e[8]);
            if (out_ready) begin
              void'(sbq.pop_front());
              if (mon_e[9]) nx_ovf = 1'b1;
              if (mon_e[8]) nx_unf = 1'b1;
            end
          end
        end
        m_sovf = nx_ovf;
        m_sunf = nx_unf;
        if (in_valid && in_ready) begin
          sbq.push_back(model({in_sign, in_norm_e, in_norm_m, in_round_up, in_zero}));
        end
      end
    end
  end

  typedef struct {
    logic [10:0] beat;
    logic [7:0]  res;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t        vt[12];
  logic [10:0] bp_beat[4];
  logic [9:0]  bp_exp[4];
  int          lat;
  int          sent;
  bit          acc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          sign  e      m      r     z                res
    vt[0]  = '{{1'b0, 4'd6,  4'h8, 1'b0, 1'b0}, 8'h38,            1'b0, 1'b0};
    vt[1]  = '{{1'b1, 4'd5,  4'hF, 1'b1, 1'b0}, 8'hB0,            1'b0, 1'b0};
    vt[2]  = '{{1'b0, 4'd9,  4'hF, 1'b1, 1'b0}, {1'b0, OvfMag},   1'b1, 1'b0};
    vt[3]  = '{{1'b1, 4'd3,  4'h0, 1'b0, 1'b0}, 8'h80,            1'b0, 1'b1};
    vt[4]  = '{{1'b0, 4'd12, 4'h5, 1'b0, 1'b1}, 8'h00,            1'b0, 1'b0};
    vt[5]  = '{{1'b0, 4'd0,  4'h5, 1'b0, 1'b0}, 8'h00,            1'b0, 1'b1};
    vt[6]  = '{{1'b0, 4'd4,  4'hF, 1'b1, 1'b0}, 8'h20,            1'b0, 1'b0};
    vt[7]  = '{{1'b0, 4'd3,  4'hF, 1'b1, 1'b0}, 8'h10,            1'b0, 1'b0};
    vt[8]  = '{{1'b0, 4'd9,  4'hF, 1'b0, 1'b0}, 8'h6F,            1'b0, 1'b0};
    vt[9]  = '{{1'b0, 4'd10, 4'h0, 1'b0, 1'b0}, {1'b0, OvfMag},   1'b1, 1'b0};
    vt[10] = '{{1'b1, 4'd15, 4'h3, 1'b0, 1'b0}, {1'b1, OvfMag},   1'b1, 1'b0};
    vt[11] = '{{1'b0, 4'd2,  4'hF, 1'b1, 1'b0}, 8'h00,            1'b0, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flags_clr = 1'b0;
    drive(11'd0);
    cyc();
    cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_unf", out_unf, 0);
    chk("rst_sticky_ovf", sticky_ovf, 0);
    chk("rst_sticky_unf", sticky_unf, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Directed vector table, one beat at a time
    for (int i = 0; i < 12; i++) begin
      send_wait(vt[i].beat, lat);
      chk($sformatf("vec%0d_latency", i), lat, 2);
      chk($sformatf("vec%0d_result", i), out_result, vt[i].res);
      chk($sformatf("vec%0d_ovf", i), out_ovf, vt[i].ovf);
      chk($sformatf("vec%0d_unf", i), out_unf, vt[i].unf);
      cyc();
    end
    chk("table_sticky_ovf", sticky_ovf, 1);
    chk("table_sticky_unf", sticky_unf, 1);

    // Clear alone, then clear coinciding with an underflow transfer
    flags_clr = 1'b1;
    cyc();
    flags_clr = 1'b0;
    chk("clr_sticky_ovf", sticky_ovf, 0);
    chk("clr_sticky_unf", sticky_unf, 0);
    send_wait({1'b1, 4'd3, 4'h0, 1'b0, 1'b0}, lat);
    cyc();
    chk("unf1_sticky_unf", sticky_unf, 1);
    send_wait({1'b1, 4'd3, 4'h0, 1'b0, 1'b0}, lat);
    chk("unf2_out_valid", out_valid, 1);
    flags_clr = 1'b1;
    cyc();
    flags_clr = 1'b0;
    chk("clr_set_sticky_unf", sticky_unf, 1);
    chk("clr_set_sticky_ovf", sticky_ovf, 0);

    // Backpressure: 4 beats offered against a stalled consumer
    for (int i = 0; i < 4; i++) begin
      bp_beat[i] = rnd_beat();
      bp_exp[i]  = model(bp_beat[i]);
    end
    out_ready = 1'b0;
    sent      = 0;
    for (int c = 0; c < 6; c++) begin
      drive(bp_beat[sent]);
      in_valid = 1'b1;
      #1;
      acc = in_ready;
      cyc();
      if (acc) sent++;
      if (c >= 2) begin
        chk("bp_stall_valid", out_valid, 1);
        chk("bp_stall_result", out_result, bp_exp[0][7:0]);
      end
    end
    chk("bp_accepted", sent, 2);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (sent < 4) begin
        drive(bp_beat[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("bp_drain_valid", out_valid, 1);
      chk("bp_drain_result", out_result, bp_exp[c][7:0]);
      acc = in_valid && in_ready;
      cyc();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", sent, 4);
    chk("bp_done_valid", out_valid, 0);

    // Reset with two beats in flight
    chk("pre_rst_sticky_unf", sticky_unf, 1);
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(rnd_beat());
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sticky_ovf", sticky_ovf, 0);
    chk("mid_rst_sticky_unf", sticky_unf, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("mid_rst_no_stale", out_valid, 0);
    end

    // Throughput: 16 back-to-back beats
    for (int c = 0; c < 20; c++) begin
      if (c < 16) begin
        drive(rnd_beat());
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 16) chk("tp_in_ready", in_ready, 1);
      chk($sformatf("tp_out_valid_c%0d", c), out_valid, (c >= 2 && c < 18) ? 1 : 0);
      cyc();
    end

    // Randomized traffic with random stalls and flag clears
    for (int c = 0; c < 400; c++) begin
      drive(rnd_beat());
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flags_clr = ($urandom_range(0, 15) == 0);
      cyc();
    end
    in_valid  = 1'b0;
    flags_clr = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();
    chk("rand_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mult_round_pack.md
Name: fp_mult_round_pack

Overview:
- Stage directly downstream of the FP multiplier execute stage.
- Consumes the product sign, the normalized exponent sum and mantissa, and the round-increment request.
- Removes the exponent bias, applies the rounding increment and renormalizes, detects overflow and underflow, and packs the 8-bit result {sign, exp[2:0], man[3:0]}.
- Two-stage registered pipeline with valid/ready handshakes on both sides.

Parameters:
- BIAS, 3, exponent bias subtracted from the incoming exponent sum.
- EXP_MAX, 7, reserved exponent code; a result exponent at or above this overflows.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_sign  in  1  product sign.
- in_norm_e  in  4  biased exponent sum, including the mantissa-overflow increment (0..15).
- in_norm_m  in  4  normalized mantissa fraction (hidden bit excluded).
- in_round_up  in  1  round-increment request from the execute stage.
- in_zero  in  1  either operand is zero.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  8  packed {sign, exp[2:0], man[3:0]}.
- out_ovf  out  1  this result overflowed.
- out_unf  out  1  this result underflowed (flushed to zero).
- flags_clr  in  1  clear the sticky flags.
- sticky_ovf  out  1  sticky overflow flag.
- sticky_unf  out  1  sticky underflow flag.

Behaviour:
- Reset: synchronous on rst. All valid bits, out_result, out_ovf, out_unf, sticky_ovf and sticky_unf are 0. in_ready is 1 in the cycle after reset. Reset asserted mid-operation discards any in-flight beats; no output is produced for them.
- Handshake: a beat transfers when valid && ready on that interface. out_valid, out_result and the per-result flags hold stable while out_valid && !out_ready.
- Pipeline:
  - S1 registers the inputs and computes the 6-bit signed exponent e1 = in_norm_e - BIAS.
  - S2 registers the rounded and packed result.
  - Each stage advances when it is empty or when its downstream accepts.
  - in_ready = !s1_valid || s2_can_load.
  - Latency is 2 cycles from input accept to out_valid with no backpressure. Throughput is 1 beat per cycle.
  - Order is preserved and no beat is dropped or duplicated.
- S2 arithmetic:
  - m5 = {1'b0, m} + round_up, 5 bits.
  - If m5[4] is set: man = 0000 and e2 = e1 + 1. Otherwise man = m5[3:0] and e2 = e1.
- S2 classification, in priority order:
  - in_zero: result {sign, 000, 0000}; ovf = 0, unf = 0.
  - e2 >= EXP_MAX: overflow; ovf = 1. The result encoding is defined under Optional Feature.
  - e2 <= 0: underflow; result {sign, 000, 0000}; unf = 1. No subnormals are produced.
  - Otherwise: result {sign, e2[2:0], man}.
- Sticky flags:
  - sticky_ovf is set on an output transfer with out_ovf = 1; sticky_unf likewise with out_unf = 1.
  - flags_clr clears both.
  - If flags_clr and a flagged transfer occur in the same cycle, set wins.

Optional Feature:
- Macro: FP_ROUND_SATURATE_EN.
- Defined: overflow produces the maximum finite value {sign, 110, 1111}; out_ovf is still 1.
- Undefined: overflow produces infinity {sign, 111, 0000}.

Test Plan:
- Normal: in_sign=0, norm_e=6, norm_m=8, round_up=0, out_ready=1 -> out_result=0x38 two cycles after accept; ovf=0, unf=0.
- Rounding carry: norm_e=5, norm_m=F, round_up=1, sign=1 -> out_result=0xB0 (exp 3, man 0); a back-to-back beat with norm_e=9, norm_m=F, round_up=1 -> ovf=1, out_result=0x70 (0x6F with FP_ROUND_SATURATE_EN); sticky_ovf=1 afterwards.
- Underflow and zero:
  - norm_e=3, sign=1 -> out_result=0x80, unf=1.
  - in_zero=1, norm_e=12 -> out_result=0x00, ovf=0, unf=0.
  - flags_clr pulsed in the same cycle as a second underflow transfer -> sticky_unf remains 1.
- Backpressure: out_ready=0 while 4 beats are offered -> 2 beats are accepted and in_ready=0 afterwards. out_result holds stable. Releasing out_ready yields all 4 results in order, one per cycle.
- Reset mid-stream: rst asserted for 1 cycle with 2 beats in flight -> out_valid=0 and sticky flags are 0 the next cycle, in_ready=1, and no stale result appears.
- Throughput: 16 consecutive beats with out_ready=1 -> 16 results on consecutive cycles starting 2 cycles after the first accept.
